// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the chunked adder/subtractor.
package add_sub_pkg;

    // Operation sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-wide slices in a WIDTH-wide operand.
    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of the chunk index; never narrower than one bit.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    // Signed overflow: both operands agree in sign but the result does not.
    // m_msb is the MSB of the (possibly inverted) second operand.
    function automatic logic calc_overflow(input logic a_msb, input logic m_msb,
                                           input logic r_msb);
        return (a_msb == m_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_chunk.sv
// CHUNK-bit ripple adder slice; the only long combinational path of the block.
module add_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    // Plain addition with carry in; maps to a CHUNK-stage carry chain.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per clock,
// least-significant chunk first, with carry/overflow/zero/negative flags.
//
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both 1; a result is consumed on a rising edge where out_valid
// and out_ready are both 1. in_ready and out_valid are pure decodes of the
// registered state, so neither depends combinationally on any input.
module chunked_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDXW   = calc_idx_w(NCHUNK);

    // state is the observable sequencer state for checkers.
    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_q;        // captured first operand
    logic [WIDTH-1:0] m_q;        // captured second operand, inverted for subtract
    logic [WIDTH-1:0] work_q;     // partial sum, kept internal until complete
    logic [WIDTH-1:0] work_nxt;
    logic             carry_q;
    logic [IDXW-1:0]  idx_q;
    logic             last_chunk;

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] m_ch;
    logic [CHUNK-1:0] sum_ch;
    logic             cout_ch;

    assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

    // Select the current chunk of each operand and merge its sum into the partial result.
    always_comb begin
        a_ch     = '0;
        m_ch     = '0;
        work_nxt = work_q;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                a_ch                         = a_q[k*CHUNK +: CHUNK];
                m_ch                         = m_q[k*CHUNK +: CHUNK];
                work_nxt[k*CHUNK +: CHUNK]   = sum_ch;
            end
        end
    end

    add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
        .a    (a_ch),
        .b    (m_ch),
        .cin  (carry_q),
        .sum  (sum_ch),
        .cout (cout_ch)
    );

    // Next-state decode: accept in IDLE, step through chunks, hold in DONE until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = BUSY;
            BUSY:    if (last_chunk) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand capture and per-chunk accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            m_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_q     <= a;
                m_q     <= op_sub ? ~b : b;
                carry_q <= op_sub;
                work_q  <= '0;
                idx_q   <= '0;
            end
        end else if (state == BUSY) begin
            work_q  <= work_nxt;
            carry_q <= cout_ch;
            idx_q   <= idx_q + IDXW'(1);
        end
    end

    // Result and flags latch only on the final chunk, so no partial value is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else if (state == BUSY && last_chunk) begin
            result    <= work_nxt;
            carry_out <= cout_ch;
            overflow  <= calc_overflow(a_q[WIDTH-1], m_q[WIDTH-1], work_nxt[WIDTH-1]);
            zero      <= (work_nxt == '0);
            negative  <= work_nxt[WIDTH-1];
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_chunked_add_sub.sv
// Bench for chunked_add_sub: directed cases on CHUNK=8, then random sweeps
// on CHUNK = 8, 1, 4 and 32 against an arithmetic reference model.
module tb_chunked_add_sub;

    logic        clk;
    logic        rst_n;

    logic        s_in_valid [4];
    logic        s_in_ready [4];
    logic [31:0] s_a        [4];
    logic [31:0] s_b        [4];
    logic        s_op       [4];
    logic        s_out_valid[4];
    logic        s_out_ready[4];
    logic [31:0] s_res      [4];
    logic        s_carry    [4];
    logic        s_ovf      [4];
    logic        s_zero     [4];
    logic        s_neg      [4];

    int total;
    int bad;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nch_of(input int g);
        return (g == 0) ? 4 : (g == 1) ? 32 : (g == 2) ? 8 : 1;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int CH = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
        chunked_add_sub #(.WIDTH(32), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (s_in_valid[g]),
            .in_ready  (s_in_ready[g]),
            .a         (s_a[g]),
            .b         (s_b[g]),
            .op_sub    (s_op[g]),
            .out_valid (s_out_valid[g]),
            .out_ready (s_out_ready[g]),
            .result    (s_res[g]),
            .carry_out (s_carry[g]),
            .overflow  (s_ovf[g]),
            .zero      (s_zero[g]),
            .negative  (s_neg[g])
        );
    end

    // ---------------- reference model ----------------
    // Returns {carry, overflow, zero, negative, result}.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub);
        longint sa, sb, ua, ub, sr;
        logic [31:0] r;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        if (sub) begin
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            sr = sa + sb;
            c  = ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
        end
        r = sr[31:0];
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {c, v, (r == 32'd0), r[31], r};
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // One full transaction on instance g, with 'hold' cycles of back-pressure in DONE.
    task automatic do_op(input int g, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input int hold, input bit wiggle);
        logic [35:0] exp_q[$];
        logic [35:0] e;
        int lat;
        int wait_n;
        exp_q.push_back(model(a, b, sub));
        wait_n = 0;
        @(negedge clk);
        while (!s_in_ready[g] && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check("in_ready_idle", 64'(s_in_ready[g]), 64'd1);
        s_a[g]         = a;
        s_b[g]         = b;
        s_op[g]        = sub;
        s_in_valid[g]  = 1'b1;
        s_out_ready[g] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after accept; captured operands must not follow them.
        s_in_valid[g] = 1'b0;
        s_a[g]        = $urandom;
        s_b[g]        = $urandom;
        s_op[g]       = 1'($urandom_range(0, 1));
        lat = 0;
        while (!s_out_valid[g] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        check("latency", 64'(lat), 64'(nch_of(g)));
        check("result", 64'(s_res[g]), 64'(e[31:0]));
        check("flags", 64'({s_carry[g], s_ovf[g], s_zero[g], s_neg[g]}), 64'(e[35:32]));
        for (int i = 0; i < hold; i++) begin
            if (wiggle) begin
                s_in_valid[g] = 1'($urandom_range(0, 1));
                s_a[g]        = $urandom;
                s_b[g]        = $urandom;
                s_op[g]       = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check("hold_result", 64'(s_res[g]), 64'(e[31:0]));
            check("hold_flags", 64'({s_carry[g], s_ovf[g], s_zero[g], s_neg[g]}), 64'(e[35:32]));
            check("hold_valid", 64'(s_out_valid[g]), 64'd1);
            check("hold_in_ready", 64'(s_in_ready[g]), 64'd0);
        end
        s_in_valid[g]  = 1'b0;
        s_out_ready[g] = 1'b1;
        @(negedge clk);
        s_out_ready[g] = 1'b0;
        check("handoff_in_ready", 64'(s_in_ready[g]), 64'd1);
        check("handoff_valid", 64'(s_out_valid[g]), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic sweep(input int g, input int n);
        for (int i = 0; i < n; i++) begin
            do_op(g, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), 1'b1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        for (int g = 0; g < 4; g++) begin
            s_in_valid[g]  = 1'b0;
            s_a[g]         = '0;
            s_b[g]         = '0;
            s_op[g]        = 1'b0;
            s_out_ready[g] = 1'b0;
        end
        #3;
        for (int g = 0; g < 4; g++) begin
            check("rst_result", 64'(s_res[g]), 64'd0);
            check("rst_flags", 64'({s_carry[g], s_ovf[g], s_zero[g], s_neg[g]}), 64'd0);
            check("rst_out_valid", 64'(s_out_valid[g]), 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(s_in_ready[0]), 64'd1);

        // Directed corner cases.
        do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        do_op(0, 32'd5, 32'd7, 1'b1, 0, 1'b0);
        do_op(0, 32'd7, 32'd5, 1'b1, 0, 1'b0);
        do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        do_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 0, 1'b0);

        // Back-pressure in DONE with wiggling inputs, then an immediate follow-up.
        do_op(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 5, 1'b1);
        do_op(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 0, 1'b0);

        // Reset during the second BUSY cycle of a nonzero operation.
        @(negedge clk);
        s_a[0]        = 32'hDEAD_BEEF;
        s_b[0]        = 32'h1111_1111;
        s_op[0]       = 1'b0;
        s_in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_in_valid[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_result", 64'(s_res[0]), 64'd0);
        check("abort_flags", 64'({s_carry[0], s_ovf[0], s_zero[0], s_neg[0]}), 64'd0);
        check("abort_out_valid", 64'(s_out_valid[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 64'(s_in_ready[0]), 64'd1);
        check("abort_no_valid", 64'(s_out_valid[0]), 64'd0);
        do_op(0, 32'd3, 32'd4, 1'b0, 0, 1'b0);

        // Random sweeps on every chunk size in parallel.
        fork
            sweep(0, 300);
            sweep(1, 1000);
            sweep(2, 1000);
            sweep(3, 1000);
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
